// File: rtl/accel_switch_pkg.sv
// rtl/accel_switch_pkg.sv - shared types and width helpers for the mesh tile switch
package accel_switch_pkg;

  function automatic int port_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  function automatic int cnt_w(input int max_hops);
    return $clog2(max_hops + 1);
  endfunction

  function automatic int route_w(input int max_hops, input int num_ports);
    return cnt_w(max_hops) + max_hops * port_w(num_ports);
  endfunction

  function automatic int cfg_w(input int data_w, input int num_ports, input int op_w,
                               input int max_hops);
    return route_w(max_hops, num_ports) + 2 * port_w(num_ports) + op_w + data_w;
  endfunction

  // Concrete packet types at the default geometry (4 ports, 3 hops, 4-bit op, 32-bit data)
  localparam int DEF_PORT_W = port_w(4);
  localparam int DEF_CNT_W  = cnt_w(3);
  localparam int DEF_HOPS_W = 3 * DEF_PORT_W;

  typedef enum logic [DEF_PORT_W-1:0] {DIR_S, DIR_E, DIR_N, DIR_W} dir_e;

  typedef struct packed {
    logic [DEF_CNT_W-1:0]  cnt;
    logic [DEF_HOPS_W-1:0] hops;
  } route_t;

  typedef struct packed {
    route_t                route;
    logic [DEF_PORT_W-1:0] in_sel;
    logic [DEF_PORT_W-1:0] out_sel;
    logic [3:0]            op;
    logic [31:0]           imm;
  } cfg_pkt_t;

endpackage

// File: rtl/skid_reg.sv
// rtl/skid_reg.sv - one-entry valid/ready pipeline register
module skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  // Refill in the same cycle the held entry drains, so a stream passes at full rate
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mesh_switch.sv
// rtl/mesh_switch.sv - tile switch: round-robin config routing/consume, PE operand/result steering
module mesh_switch
  import accel_switch_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_PORTS = 4,
  parameter int NUM_OPND  = 3,
  parameter int OP_W      = 4,
  parameter int MAX_HOPS  = 3,
  parameter int OST_MAX   = 3,
  localparam int PORT_W   = port_w(NUM_PORTS),
  localparam int CNT_W    = cnt_w(MAX_HOPS),
  localparam int HOPS_W   = MAX_HOPS * PORT_W,
  localparam int ROUTE_W  = route_w(MAX_HOPS, NUM_PORTS),
  localparam int CFG_W    = cfg_w(DATA_W, NUM_PORTS, OP_W, MAX_HOPS),
  localparam int OST_W    = $clog2(OST_MAX + 1)
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        load,
  input  logic [NUM_PORTS-1:0]                        cfg_in_valid,
  input  logic [NUM_PORTS-1:0][CFG_W-1:0]             cfg_in_data,
  output logic [NUM_PORTS-1:0]                        cfg_in_ready,
  output logic [NUM_PORTS-1:0]                        cfg_out_valid,
  output logic [NUM_PORTS-1:0][CFG_W-1:0]             cfg_out_data,
  input  logic [NUM_PORTS-1:0]                        cfg_out_ready,
  output logic                                        cfg_done,
  output logic                                        configured,
  input  logic [NUM_PORTS-1:0]                        in_valid,
  input  logic [NUM_PORTS-1:0][NUM_OPND-1:0][DATA_W-1:0] in_data,
  output logic [NUM_PORTS-1:0]                        in_ready,
  output logic                                        pe_valid,
  input  logic                                        pe_ready,
  output logic [OP_W-1:0]                             pe_op,
  output logic [DATA_W-1:0]                           pe_imm,
  output logic [NUM_OPND-1:0][DATA_W-1:0]             pe_opnd,
  input  logic                                        pe_res_valid,
  input  logic [DATA_W-1:0]                           pe_res_data,
  output logic                                        pe_res_ready,
  output logic [NUM_PORTS-1:0]                        out_valid,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]            out_data,
  input  logic [NUM_PORTS-1:0]                        out_ready
);

  logic [PORT_W-1:0]    rr_ptr, gnt_idx, dir, in_sel_q, out_sel_q;
  logic                 gnt_valid, is_local, can_accept, cfg_hs;
  logic [CFG_W-1:0]     gnt_pkt, fwd_pkt;
  logic [ROUTE_W-1:0]   route;
  logic [CNT_W-1:0]     cnt;
  logic [HOPS_W-1:0]    hops;
  logic [NUM_PORTS-1:0] fwd_in_valid, fwd_in_ready;
  logic [OST_W-1:0]     ost;
  logic                 run, ost_ok, issue, res_in_ready, res_hs, res_valid;
  logic [DATA_W-1:0]    res_data;

  // Round-robin search starts one past the last winner
  always_comb begin
    int idx;
    logic [PORT_W-1:0] idx_p;
    idx       = 0;
    idx_p     = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (load) begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        idx   = (int'(rr_ptr) + k) % NUM_PORTS;
        idx_p = PORT_W'(idx);
        if (!gnt_valid && cfg_in_valid[idx_p]) begin
          gnt_valid = 1'b1;
          gnt_idx   = idx_p;
        end
      end
    end
  end

  assign gnt_pkt  = cfg_in_data[gnt_idx];
  assign route    = gnt_pkt[CFG_W-1 -: ROUTE_W];
  assign cnt      = route[ROUTE_W-1 -: CNT_W];
  assign hops     = route[HOPS_W-1:0];
  assign dir      = hops[PORT_W-1:0];
  assign is_local = (cnt == '0);
  assign fwd_pkt  = {cnt - CNT_W'(1), hops >> PORT_W, gnt_pkt[CFG_W-ROUTE_W-1:0]};

  // A local consume must not swap the opcode under ops or results still in flight
  assign can_accept = is_local ? ((ost == '0) && !res_valid) : fwd_in_ready[dir];
  assign cfg_hs     = gnt_valid && can_accept;

  always_comb begin
    cfg_in_ready = '0;
    fwd_in_valid = '0;
    if (cfg_hs) begin
      cfg_in_ready[gnt_idx] = 1'b1;
      if (!is_local) fwd_in_valid[dir] = 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fwd
    skid_reg #(.WIDTH(CFG_W)) u_fwd (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (fwd_in_valid[p]),
      .in_data   (fwd_pkt),
      .in_ready  (fwd_in_ready[p]),
      .out_valid (cfg_out_valid[p]),
      .out_data  (cfg_out_data[p]),
      .out_ready (cfg_out_ready[p])
    );
  end

  assign run     = !load && configured;
  assign ost_ok  = ost < OST_W'(OST_MAX);
  assign pe_valid = run && in_valid[in_sel_q] && ost_ok;
  assign pe_opnd = in_data[in_sel_q];
  assign issue   = pe_valid && pe_ready;

  always_comb begin
    in_ready = '0;
    if (run && pe_ready && ost_ok) in_ready[in_sel_q] = 1'b1;
  end

  // Results are only accepted against an outstanding op, which also keeps the count from wrapping
  assign pe_res_ready = res_in_ready && (ost != '0);
  assign res_hs       = pe_res_valid && pe_res_ready;

  skid_reg #(.WIDTH(DATA_W)) u_res (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (pe_res_valid && (ost != '0)),
    .in_data   (pe_res_data),
    .in_ready  (res_in_ready),
    .out_valid (res_valid),
    .out_data  (res_data),
    .out_ready (out_ready[out_sel_q])
  );

  always_comb begin
    out_valid            = '0;
    out_data             = '0;
    out_valid[out_sel_q] = res_valid;
    out_data[out_sel_q]  = res_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      in_sel_q   <= '0;
      out_sel_q  <= '0;
      pe_op      <= '0;
      pe_imm     <= '0;
      configured <= 1'b0;
      cfg_done   <= 1'b0;
      ost        <= '0;
    end else begin
      cfg_done <= 1'b0;
      if (cfg_hs) begin
        rr_ptr <= gnt_idx;
        if (is_local) begin
          in_sel_q   <= gnt_pkt[DATA_W+OP_W+PORT_W +: PORT_W];
          out_sel_q  <= gnt_pkt[DATA_W+OP_W +: PORT_W];
          pe_op      <= gnt_pkt[DATA_W +: OP_W];
          pe_imm     <= gnt_pkt[DATA_W-1:0];
          configured <= 1'b1;
          cfg_done   <= 1'b1;
        end
      end
      case ({issue, res_hs})
        2'b10:   ost <= ost + OST_W'(1);
        2'b01:   ost <= ost - OST_W'(1);
        default: ost <= ost;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_switch.sv
// tb/tb_mesh_switch.sv - directed self-checking bench for mesh_switch
module tb_mesh_switch;
  import accel_switch_pkg::*;

  logic clk = 1'b0;
  logic reset, load;
  logic [3:0]            cfg_in_valid, cfg_in_ready, cfg_out_valid, cfg_out_ready;
  logic [3:0][47:0]      cfg_in_data, cfg_out_data;
  logic                  cfg_done, configured;
  logic [3:0]            in_valid, in_ready;
  logic [3:0][2:0][31:0] in_data;
  logic                  pe_valid, pe_ready;
  logic [3:0]            pe_op;
  logic [31:0]           pe_imm;
  logic [2:0][31:0]      pe_opnd;
  logic                  pe_res_valid, pe_res_ready;
  logic [31:0]           pe_res_data;
  logic [3:0]            out_valid, out_ready;
  logic [3:0][31:0]      out_data;

  int n_checks = 0;
  int n_errors = 0;

  mesh_switch dut (
    .clk(clk), .reset(reset), .load(load),
    .cfg_in_valid(cfg_in_valid), .cfg_in_data(cfg_in_data), .cfg_in_ready(cfg_in_ready),
    .cfg_out_valid(cfg_out_valid), .cfg_out_data(cfg_out_data), .cfg_out_ready(cfg_out_ready),
    .cfg_done(cfg_done), .configured(configured),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_op(pe_op), .pe_imm(pe_imm), .pe_opnd(pe_opnd),
    .pe_res_valid(pe_res_valid), .pe_res_data(pe_res_data), .pe_res_ready(pe_res_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] mk_pkt(input logic [1:0] cnt, input logic [5:0] hops,
                                         input logic [1:0] isel, input logic [1:0] osel,
                                         input logic [3:0] op, input logic [31:0] imm);
    cfg_pkt_t p;
    p.route.cnt  = cnt;
    p.route.hops = hops;
    p.in_sel     = isel;
    p.out_sel    = osel;
    p.op         = op;
    p.imm        = imm;
    return p;
  endfunction

  int grant_exp [6] = '{1, 3, 0, 1, 3, 0};

  initial begin
    reset = 1'b1; load = 1'b0;
    cfg_in_valid = '0; cfg_in_data = '0; cfg_out_ready = '0;
    in_valid = '0; in_data = '0; pe_ready = 1'b0;
    pe_res_valid = 1'b0; pe_res_data = '0; out_ready = '0;
    tick(); tick();

    // Reset state
    check("rst_configured", 64'(configured), 64'd0);
    check("rst_cfg_done", 64'(cfg_done), 64'd0);
    check("rst_cfg_out_valid", 64'(cfg_out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_pe_valid", 64'(pe_valid), 64'd0);
    check("rst_pe_res_ready", 64'(pe_res_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_pe_op_imm", {28'd0, pe_op, pe_imm}, 64'd0);
    reset = 1'b0;

    // Local consume on port 2
    load = 1'b1;
    cfg_in_valid = 4'b0100;
    cfg_in_data[2] = mk_pkt(2'd0, 6'd0, 2'd1, 2'd3, 4'h5, 32'hDEADBEEF);
    #1;
    check("local_ready", 64'(cfg_in_ready), 64'b0100);
    tick();
    cfg_in_valid = '0;
    #1;
    check("local_done", 64'(cfg_done), 64'd1);
    check("local_configured", 64'(configured), 64'd1);
    check("local_op", 64'(pe_op), 64'h5);
    check("local_imm", 64'(pe_imm), 64'hDEADBEEF);
    tick();
    check("local_done_pulse", 64'(cfg_done), 64'd0);

    // Forward from port 0 east, then stall a second east packet behind it
    cfg_in_valid = 4'b0001;
    cfg_in_data[0] = mk_pkt(2'd2, 6'b00_10_01, 2'd2, 2'd1, 4'hA, 32'h12345678);
    #1;
    check("fwd_ready", 64'(cfg_in_ready), 64'b0001);
    tick();
    cfg_in_data[0] = mk_pkt(2'd1, 6'b00_00_01, 2'd0, 2'd2, 4'h3, 32'h0BADF00D);
    #1;
    check("fwd_out_valid", 64'(cfg_out_valid), 64'b0010);
    check("fwd_out_data", 64'(cfg_out_data[1]), 64'(mk_pkt(2'd1, 6'b00_00_10, 2'd2, 2'd1, 4'hA, 32'h12345678)));
    check("fwd_stall_ready", 64'(cfg_in_ready), 64'd0);
    tick();
    check("fwd_stall_hold", 64'(cfg_out_data[1]), 64'(mk_pkt(2'd1, 6'b00_00_10, 2'd2, 2'd1, 4'hA, 32'h12345678)));
    cfg_out_ready = 4'b0010;
    #1;
    check("fwd_drain_ready", 64'(cfg_in_ready), 64'b0001);
    tick();
    cfg_in_valid = '0;
    #1;
    check("fwd_second_data", 64'(cfg_out_data[1]), 64'(mk_pkt(2'd0, 6'd0, 2'd0, 2'd2, 4'h3, 32'h0BADF00D)));
    tick();
    check("fwd_empty", 64'(cfg_out_valid), 64'd0);

    // Contention: ports 0,1,3 forwarding south with all outputs ready
    cfg_out_ready = 4'b1111;
    for (int p = 0; p < 4; p++) cfg_in_data[p] = mk_pkt(2'd1, 6'd0, 2'd0, 2'd0, 4'(p), 32'(p));
    cfg_in_valid = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rr_grant%0d", i), 64'(cfg_in_ready), 64'(4'b0001 << grant_exp[i]));
      tick();
    end
    cfg_in_valid = '0;
    tick(); tick();

    // Run phase: three bundles on port 1, OST limit, result backpressure on port 3
    load = 1'b0;
    pe_ready = 1'b1;
    in_valid = 4'b0010;
    for (int v = 1; v <= 3; v++) begin
      in_data[1][0] = 32'(v);
      #1;
      check($sformatf("run_issue%0d", v), {31'd0, pe_valid, 28'd0, in_ready}, {31'd0, 1'b1, 28'd0, 4'b0010});
      check($sformatf("run_opnd%0d", v), 64'(pe_opnd[0]), 64'(v));
      tick();
    end
    in_data[1][0] = 32'd4;
    #1;
    check("run_limit", {31'd0, pe_valid, 28'd0, in_ready}, 64'd0);
    in_valid = '0;
    pe_res_valid = 1'b1; pe_res_data = 32'd1; out_ready = 4'b1000;
    tick();
    pe_res_data = 32'd2; out_ready = 4'b0000;
    #1;
    check("res1_out", {28'd0, out_valid, out_data[3]}, {28'd0, 4'b1000, 32'd1});
    check("res_bp_ready", 64'(pe_res_ready), 64'd0);
    check("run_unlimit", 64'(in_ready), 64'b0010);
    tick();
    check("res1_hold", 64'(out_data[3]), 64'd1);
    out_ready = 4'b1000;
    tick();
    pe_res_data = 32'd3;
    #1;
    check("res2_out", {28'd0, out_valid, out_data[3]}, {28'd0, 4'b1000, 32'd2});
    tick();
    pe_res_valid = 1'b0;
    #1;
    check("res3_out", {28'd0, out_valid, out_data[3]}, {28'd0, 4'b1000, 32'd3});
    tick();
    check("res_drained", 64'(out_valid), 64'd0);

    // Reconfig guard: two ops outstanding block a local packet
    in_valid = 4'b0010;
    tick(); tick();
    in_valid = '0;
    load = 1'b1;
    cfg_in_valid = 4'b0100;
    cfg_in_data[2] = mk_pkt(2'd0, 6'd0, 2'd1, 2'd3, 4'h7, 32'hCAFEF00D);
    #1;
    check("guard_ost2", 64'(cfg_in_ready), 64'd0);
    pe_res_valid = 1'b1; pe_res_data = 32'd11;
    tick();
    check("guard_ost1", 64'(cfg_in_ready), 64'd0);
    pe_res_data = 32'd12;
    tick();
    pe_res_valid = 1'b0;
    #1;
    check("guard_reg_full", 64'(cfg_in_ready), 64'd0);
    tick();
    check("guard_accept", 64'(cfg_in_ready), 64'b0100);
    tick();
    cfg_in_valid = '0;
    #1;
    check("guard_done", {31'd0, cfg_done, 28'd0, pe_op}, {31'd0, 1'b1, 28'd0, 4'h7});

    // Reset mid-operation with a full forward buffer and one op outstanding
    load = 1'b0;
    in_valid = 4'b0010;
    tick();
    in_valid = '0;
    load = 1'b1;
    cfg_out_ready = '0;
    cfg_in_valid = 4'b0001;
    cfg_in_data[0] = mk_pkt(2'd1, 6'b00_00_01, 2'd0, 2'd0, 4'h1, 32'h1);
    tick();
    check("pre_rst_full", 64'(cfg_out_valid), 64'b0010);
    cfg_in_valid = 4'b0110;
    cfg_in_data[1] = mk_pkt(2'd0, 6'd0, 2'd2, 2'd2, 4'h9, 32'h99);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_cfg_out", 64'(cfg_out_valid), 64'd0);
    check("mid_rst_configured", {31'd0, configured, 31'd0, cfg_done}, 64'd0);
    check("mid_rst_pe_op", 64'(pe_op), 64'd0);
    check("mid_rst_ptr_ost", 64'(cfg_in_ready), 64'b0010);
    tick();
    cfg_in_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
